dvp_capture_ctrl: RTL
=====================

// Module: dvp_capture_ctrl
// PURPOSE
//  Sequences the DVP camera byte stream into RGB565 pixels ahead of the RGB888 expander/TMDS path.
//  - Tracks vsync/href framing and pairs hi/lo bytes.
//  - Generates pixel coordinates and SOF/EOL markers.
//  - Flags malformed lines and frames.
//  - Sits in the dvp_clk domain, directly after the sensor pins.
// PARAMETERS
//  H_ACTIVE   640  expected pixels per line (bytes = 2*H_ACTIVE)
//  V_ACTIVE   480  expected lines per frame
//  VSYNC_POL  1    1: dvp_vsync active-high; 0: active-low
//  CW         12   width of pix_x / pix_y / stats counters
// PORTS
//  dvp_clk     in   1     pixel-byte clock; single clock of the block
//  rst         in   1     synchronous, active-high reset
//  cap_en      in   1     capture enable; arming waits for a full vsync pulse
//  dvp_vsync   in   1     sensor vsync (polarity per VSYNC_POL)
//  dvp_href    in   1     sensor line-valid, active-high
//  dvp_data    in   8     sensor byte; RGB565 hi byte first
//  pix_data    out  16    paired RGB565 pixel {hi, lo}
//  pix_valid   out  1     one-cycle strobe per pixel
//  pix_sof     out  1     with pix_valid: pixel (0,0) of a frame
//  pix_eol     out  1     with pix_valid: pixel x == H_ACTIVE-1
//  pix_x       out  CW    column of current pix_data
//  pix_y       out  CW    row of current pix_data
//  frame_done  out  1     one-cycle pulse at vsync assert closing a captured frame
//  err         out  3     one-cycle pulses: [0] odd byte count, [1] line length != H_ACTIVE, [2] line count != V_ACTIVE
// BEHAVIOUR
//  Input stage and reset
//  - vsync, href and data are registered once at the pins before any use.
//  - All outputs reset to 0. FSM resets to S_IDLE, byte phase to HI, counters to 0.
//  FSM
//  - S_IDLE: leave when cap_en=1 -> S_ARM.
//  - S_ARM: wait for vsync asserted -> S_VS. Never starts mid-frame.
//  - S_VS: on vsync deassert -> S_FRAME, with x=y=0 and sof_pending=1.
//  - S_FRAME: capture href bytes. On vsync assert:
//    - pulse frame_done and check the line count (err[2] if != V_ACTIVE);
//    - then -> S_VS if cap_en=1, else -> S_IDLE.
//  - cap_en=0 in S_ARM/S_VS -> S_IDLE immediately.
//  - cap_en=0 in S_FRAME: finish the frame, then -> S_IDLE.
//  Byte pairing (S_FRAME only)
//  - The first registered byte with href=1 is HI; the next is LO; phase toggles per byte.
//  - Latency: pix_valid pulses 2 dvp_clk after the edge that samples the LO byte at the pins.
//  - pix_data/x/y hold until the next pix_valid.
//  Coordinates and markers
//  - x increments after each pixel.
//  - Pixels with x >= H_ACTIVE are dropped: no pix_valid.
//  - pix_sof on the first pixel after sof_pending, then sof_pending clears.
//  - pix_eol when x == H_ACTIVE-1.
//  End of line (href falling edge)
//  - If phase==LO: dangling HI byte discarded, err[0] pulses.
//  - If pixel count != H_ACTIVE: err[1] pulses.
//  - If >= 1 pixel was seen: y increments, saturating at 2^CW-1.
//  - x and phase reset.
//  - Lines with y >= V_ACTIVE emit no pix_valid but are still counted.
//  Edge cases
//  - vsync asserting while href=1: line aborted, no eol check, err[1] pulses, then the frame closes as normal.
//  - href high in S_IDLE/S_ARM/S_VS is ignored entirely.
//  - Error pulses are evaluated the cycle after the registered edge.
//  - Simultaneous errors assert together in the same cycle.
//  - rst mid-frame: immediate return to reset state; the next capture needs a fresh vsync.
// CONFIGURATION
//  DVP_CAPTURE_STATS_EN
//  - Defined: adds outputs that update at frame_done (all reset 0):
//    - stat_frames[15:0], wraps;
//    - stat_last_px[CW-1:0], pixels in the last line;
//    - stat_lines[CW-1:0], lines in the last frame.
//  - Undefined: these ports do not exist and no stats logic is built.
// STRUCTURE
//  Package dvp_pkg:
//  - cap_state_e {S_IDLE, S_ARM, S_VS, S_FRAME};
//  - rgb565_t packed struct {r[4:0], g[5:0], b[4:0]};
//  - err bit index localparams ERR_ODD=0, ERR_HLEN=1, ERR_VLEN=2.
//  Sub-module dvp_byte_pairer:
//  - phase register + HI-byte holding register;
//  - outputs pair strobe, and a dangling flag on href fall.
//  - FSM, counters and error logic stay in dvp_capture_ctrl.
// TESTING
//  Scenarios use H_ACTIVE=4 and V_ACTIVE=2.
//  1. Nominal: cap_en=1; vsync pulse, 2 lines of 8 bytes 0x01..0x08.
//     -> 4 pix_valid/line, first pix_data=0x0102 with pix_sof.
//     -> pix_eol at x=3; frame_done at next vsync; err=0.
//  2. Odd line: line of 7 bytes.
//     -> 3 pixels, err[0] and err[1] pulse at href fall; y still increments.
//  3. Arm mid-frame: cap_en rises during href activity.
//     -> no pix_valid until after the next full vsync pulse.
//  4. Overlong/short frame: line of 10 bytes, then 3 lines.
//     -> 4 pixels (5th dropped) and err[1]; err[2] with frame_done.
//  5. Abort: vsync asserts mid-line, then rst pulsed mid-frame.
//     -> err[1] and frame_done; after rst all outputs 0, FSM re-arms.
//  6. With DVP_CAPTURE_STATS_EN: after 3 nominal frames.
//     -> stat_frames=3, stat_last_px=4, stat_lines=2.

Source files
------------

// File: rtl/dvp_pkg.sv
// Shared types for the DVP capture path: FSM states, RGB565 pixel layout, err bit indices.
package dvp_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_VS, S_FRAME} cap_state_e;

    typedef enum logic {PH_HI, PH_LO} byte_phase_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam int ERR_ODD  = 0;
    localparam int ERR_HLEN = 1;
    localparam int ERR_VLEN = 2;

endpackage

// File: rtl/dvp_byte_pairer.sv
// Pairs registered DVP bytes into RGB565 words (hi byte first) and reports the
// end of each href line, flagging a dangling hi byte.
module dvp_byte_pairer
    import dvp_pkg::*;
(
    input  logic       dvp_clk,
    input  logic       rst,
    input  logic       en,
    input  logic       href,
    input  logic [7:0] data,
    output logic       pair_stb,
    output rgb565_t    pair_data,
    output logic       line_end,
    output logic       dangling
);

    byte_phase_e phase;
    logic [7:0]  hi_q;
    logic        href_prev;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge dvp_clk) begin
        if (rst) begin
            phase     <= PH_HI;
            hi_q      <= '0;
            href_prev <= 1'b0;
            pair_stb  <= 1'b0;
            pair_data <= '0;
            line_end  <= 1'b0;
            dangling  <= 1'b0;
        end else begin
            pair_stb  <= 1'b0;
            line_end  <= 1'b0;
            dangling  <= 1'b0;
            href_prev <= en && href;
            if (!en) begin
                phase <= PH_HI;
            end else if (href) begin
                if (phase == PH_HI) begin
                    hi_q  <= data;
                    phase <= PH_LO;
                end else begin
                    pair_data <= {hi_q, data};
                    pair_stb  <= 1'b1;
                    phase     <= PH_HI;
                end
            end else if (href_prev) begin
                // href just fell: a pending hi byte has no partner and is dropped
                line_end <= 1'b1;
                dangling <= (phase == PH_LO);
                phase    <= PH_HI;
            end
        end
    end

endmodule

// File: rtl/dvp_capture_ctrl.sv
// DVP capture sequencer: vsync/href framing, pixel coordinates, SOF/EOL and error pulses.
// Optional per-frame statistics outputs are built when DVP_CAPTURE_STATS_EN is defined.
module dvp_capture_ctrl
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int VSYNC_POL = 1,
    parameter int CW        = 12
) (
    input  logic          dvp_clk,
    input  logic          rst,
    input  logic          cap_en,
    input  logic          dvp_vsync,
    input  logic          dvp_href,
    input  logic [7:0]    dvp_data,
    output logic [15:0]   pix_data,
    output logic          pix_valid,
    output logic          pix_sof,
    output logic          pix_eol,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          frame_done,
    output logic [2:0]    err
`ifdef DVP_CAPTURE_STATS_EN
    ,
    output logic [15:0]   stat_frames,
    output logic [CW-1:0] stat_last_px,
    output logic [CW-1:0] stat_lines
`endif
);

    localparam logic [CW-1:0] H_LEN   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_LAST  = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_LEN   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic       vs_raw_r, href_r;
    logic [7:0] data_r;

    always_ff @(posedge dvp_clk) begin
        if (rst) begin
            vs_raw_r <= 1'b0;
            href_r   <= 1'b0;
            data_r   <= '0;
        end else begin
            vs_raw_r <= dvp_vsync;
            href_r   <= dvp_href;
            data_r   <= dvp_data;
        end
    end

    cap_state_e    state;
    logic [CW-1:0] x_cnt, y_cnt, y_next;
    logic          sof_pending;
    logic          vs_act, close_frame;
    logic          pair_stb, line_end, dangling;
    rgb565_t       pair_data;

    assign vs_act      = (VSYNC_POL != 0) ? vs_raw_r : ~vs_raw_r;
    assign close_frame = (state == S_FRAME) && vs_act;
    // a line that ends in the closing cycle still counts toward the frame
    assign y_next      = (line_end && x_cnt != '0 && y_cnt != CNT_MAX) ? y_cnt + CW'(1) : y_cnt;

    dvp_byte_pairer u_pairer (
        .dvp_clk   (dvp_clk),
        .rst       (rst),
        .en        (state == S_FRAME),
        .href      (href_r),
        .data      (data_r),
        .pair_stb  (pair_stb),
        .pair_data (pair_data),
        .line_end  (line_end),
        .dangling  (dangling)
    );

    always_ff @(posedge dvp_clk) begin
        if (rst) begin
            state       <= S_IDLE;
            x_cnt       <= '0;
            y_cnt       <= '0;
            sof_pending <= 1'b0;
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            pix_sof     <= 1'b0;
            pix_eol     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_done  <= 1'b0;
            err         <= '0;
        end else begin
            pix_valid  <= 1'b0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            frame_done <= 1'b0;
            err        <= '0;
            unique case (state)
                S_IDLE: if (cap_en) state <= S_ARM;
                S_ARM: begin
                    if (!cap_en)     state <= S_IDLE;
                    else if (vs_act) state <= S_VS;
                end
                S_VS: begin
                    if (!cap_en) begin
                        state <= S_IDLE;
                    end else if (!vs_act) begin
                        state       <= S_FRAME;
                        x_cnt       <= '0;
                        y_cnt       <= '0;
                        sof_pending <= 1'b1;
                    end
                end
                S_FRAME: begin
                    if (vs_act) begin
                        frame_done     <= 1'b1;
                        err[ERR_VLEN]  <= (y_next != V_LEN);
                        err[ERR_HLEN]  <= href_r;
                        state          <= cap_en ? S_VS : S_IDLE;
                    end else begin
                        if (pair_stb) begin
                            if (x_cnt < H_LEN && y_cnt < V_LEN) begin
                                pix_valid   <= 1'b1;
                                pix_data    <= pair_data;
                                pix_x       <= x_cnt;
                                pix_y       <= y_cnt;
                                pix_sof     <= sof_pending;
                                pix_eol     <= (x_cnt == H_LAST);
                                sof_pending <= 1'b0;
                            end
                            if (x_cnt != CNT_MAX) x_cnt <= x_cnt + CW'(1);
                        end
                        if (line_end) begin
                            err[ERR_ODD]  <= dangling;
                            err[ERR_HLEN] <= (x_cnt != H_LEN);
                            y_cnt         <= y_next;
                            x_cnt         <= '0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DVP_CAPTURE_STATS_EN
    logic [CW-1:0] line_px_r;

    always_ff @(posedge dvp_clk) begin
        if (rst) begin
            line_px_r    <= '0;
            stat_frames  <= '0;
            stat_last_px <= '0;
            stat_lines   <= '0;
        end else begin
            if (state == S_FRAME && !vs_act && line_end) line_px_r <= x_cnt;
            if (close_frame) begin
                stat_frames  <= stat_frames + 16'd1;
                stat_last_px <= line_end ? x_cnt : line_px_r;
                stat_lines   <= y_next;
            end
        end
    end
`endif

endmodule
